// File: rtl/rv_decode_pkg.sv
// Shared constants, decoded-bundle layout and ALU helper for the RV32I/RV64I decode stage.
package rv_decode_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd9;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    // Width-independent part of the decoded bundle; pc and imm travel alongside.
    typedef struct packed {
        logic [ALU_W-1:0] alu;
        logic [5:0]       shamt;
        logic [1:0]       src_a;
        logic [1:0]       src_b;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [2:0]       funct3;
        logic             branch;
        logic             rd_mem;
        logic             wr_mem;
        logic             wr_pc;
        logic             wr_reg;
        logic             illegal;
    } dec_t;

    localparam int unsigned DEC_W = $bits(dec_t);

    // alt selects SUB over ADD and SRA over SRL (instruction bit 30).
    function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_decode_stage_comb.sv
// Purely combinational instruction word -> decoded bundle and sign-extended immediate.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]      inst_i,
    output logic [DEC_W-1:0] dec_o,
    output logic [XLEN-1:0]  imm_o
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            shift_hi_bad;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    dec_t            d;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];

    assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = XLEN'($signed({inst_i[31:12], 12'h000}));
    assign imm_j = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Shift-immediate upper bits other than bit 30 must be zero; bit 25 is shamt[5] only on RV64.
    assign shift_hi_bad = (|{inst_i[31], inst_i[29:26]}) | ((XLEN != 64) & inst_i[25]);

    always_comb begin
        d        = '0;
        d.alu    = ALU_ADD;
        d.src_a  = SRC_A_RS1;
        d.src_b  = SRC_B_RS2;
        d.rs1    = inst_i[19:15];
        d.rs2    = inst_i[24:20];
        d.rd     = inst_i[11:7];
        d.funct3 = f3;
        d.shamt  = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
        imm_o    = imm_i;

        case (opcode)
            OPC_LUI: begin
                d.src_a = SRC_A_ZERO;  d.src_b = SRC_B_IMM;  imm_o = imm_u;  d.wr_reg = 1'b1;
            end
            OPC_AUIPC: begin
                d.src_a = SRC_A_PC;    d.src_b = SRC_B_IMM;  imm_o = imm_u;  d.wr_reg = 1'b1;
            end
            OPC_JAL: begin
                d.src_a = SRC_A_PC;    d.src_b = SRC_B_FOUR; imm_o = imm_j;
                d.wr_pc = 1'b1;        d.wr_reg = 1'b1;
            end
            OPC_JALR: begin
                d.src_a = SRC_A_PC;    d.src_b = SRC_B_FOUR;
                d.wr_pc = 1'b1;        d.wr_reg = 1'b1;
            end
            OPC_BRANCH: begin
                d.alu = ALU_SUB;       imm_o = imm_b;        d.branch = 1'b1;
            end
            OPC_LOAD: begin
                d.src_b = SRC_B_IMM;   d.rd_mem = 1'b1;      d.wr_reg = 1'b1;
            end
            OPC_STORE: begin
                d.src_b = SRC_B_IMM;   imm_o = imm_s;        d.wr_mem = 1'b1;
            end
            OPC_OP_IMM: begin
                d.src_b  = SRC_B_IMM;
                d.wr_reg = 1'b1;
                d.alu    = alu_from_f3(f3, (f3 == 3'b101) & inst_i[30]);
                if (f3 == 3'b001 && (shift_hi_bad || inst_i[30])) d.illegal = 1'b1;
                if (f3 == 3'b101 && shift_hi_bad)                 d.illegal = 1'b1;
            end
            OPC_OP: begin
                d.wr_reg = 1'b1;
                d.alu    = alu_from_f3(f3, inst_i[30]);
                if (!(f7 == 7'b0000000 ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
                    d.illegal = 1'b1;
            end
            OPC_MISC_MEM: ;
            default: d.illegal = 1'b1;
        endcase

        if (inst_i[1:0] != 2'b11) d.illegal = 1'b1;
        if (d.illegal) begin
            d.branch = 1'b0;
            d.rd_mem = 1'b0;
            d.wr_mem = 1'b0;
            d.wr_pc  = 1'b0;
            d.wr_reg = 1'b0;
        end
        if (d.rd == 5'd0) d.wr_reg = 1'b0;
        dec_o = d;
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Decode pipeline stage: input-side decoder, output register, optional skid slot and flush.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ALU_OP_W = 4,
    parameter int unsigned SKID     = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         inst_i,
    input  logic [XLEN-1:0]     pc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     out_pc_o,
    output logic [ALU_OP_W-1:0] ALUControl_o,
    output logic [XLEN-1:0]     imm_o,
    output logic [5:0]          shamt_o,
    output logic [1:0]          srcAE_o,
    output logic [1:0]          srcBE_o,
    output logic [4:0]          rs1_o,
    output logic [4:0]          rs2_o,
    output logic [4:0]          rd_o,
    output logic [2:0]          funct3_o,
    output logic                Branch_o,
    output logic                RdMem_o,
    output logic                WrMem_o,
    output logic                WrPc_o,
    output logic                WrReg_o,
    output logic                illegal_o
);

    logic [DEC_W-1:0] in_dec;
    logic [XLEN-1:0]  in_imm;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_pc_q,    out_pc_d;
    logic [XLEN-1:0]  out_imm_q,   out_imm_d;
    logic [DEC_W-1:0] out_dec_q,   out_dec_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_pc_q,   skid_pc_d;
    logic [XLEN-1:0]  skid_imm_q,  skid_imm_d;
    logic [DEC_W-1:0] skid_dec_q,  skid_dec_d;
    dec_t             out_dec;

    rv_decode_comb #(.XLEN(XLEN)) u_comb (
        .inst_i (inst_i),
        .dec_o  (in_dec),
        .imm_o  (in_imm)
    );

    assign in_ready_o = (SKID != 0) ? ~skid_valid_q : (out_ready_i | ~out_valid_q);

    // Output register refills from the skid slot first so order is preserved.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_imm_d    = out_imm_q;
        out_dec_d    = out_dec_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_imm_d   = skid_imm_q;
        skid_dec_d   = skid_dec_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_imm_d    = skid_imm_q;
                out_dec_d    = skid_dec_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid_i;
                if (in_valid_i) begin
                    out_pc_d  = pc_i;
                    out_imm_d = in_imm;
                    out_dec_d = in_dec;
                end
            end
        end else if (SKID != 0 && in_valid_i && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_i;
            skid_imm_d   = in_imm;
            skid_dec_d   = in_dec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_imm_q    <= '0;
            out_dec_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_imm_q   <= '0;
            skid_dec_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_imm_q    <= out_imm_d;
            out_dec_q    <= out_dec_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_imm_q   <= skid_imm_d;
            skid_dec_q   <= skid_dec_d;
        end
    end

    assign out_dec      = out_dec_q;
    assign out_valid_o  = out_valid_q;
    assign out_pc_o     = out_pc_q;
    assign imm_o        = out_imm_q;
    assign ALUControl_o = ALU_OP_W'(out_dec.alu);
    assign shamt_o      = out_dec.shamt;
    assign srcAE_o      = out_dec.src_a;
    assign srcBE_o      = out_dec.src_b;
    assign rs1_o        = out_dec.rs1;
    assign rs2_o        = out_dec.rs2;
    assign rd_o         = out_dec.rd;
    assign funct3_o     = out_dec.funct3;
    assign Branch_o     = out_dec.branch;
    assign RdMem_o      = out_dec.rd_mem;
    assign WrMem_o      = out_dec.wr_mem;
    assign WrPc_o       = out_dec.wr_pc;
    assign WrReg_o      = out_dec.wr_reg;
    assign illegal_o    = out_dec.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Randomized bench for rv_decode_stage (RV32, skid on) against an architectural decode model and scoreboard.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [31:0] inst_i, pc_i, out_pc_o, imm_o;
    logic [3:0]  ALUControl_o;
    logic [5:0]  shamt_o;
    logic [1:0]  srcAE_o, srcBE_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [2:0]  funct3_o;
    logic        Branch_o, RdMem_o, WrMem_o, WrPc_o, WrReg_o, illegal_o;

    rv_decode_stage #(.XLEN(32), .ALU_OP_W(4), .SKID(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .ALUControl_o(ALUControl_o), .imm_o(imm_o),
        .shamt_o(shamt_o), .srcAE_o(srcAE_o), .srcBE_o(srcBE_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o),
        .Branch_o(Branch_o), .RdMem_o(RdMem_o), .WrMem_o(WrMem_o),
        .WrPc_o(WrPc_o), .WrReg_o(WrReg_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        int          alu;
        int          sa;
        int          sb;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [5:0]  shamt;
        bit          br, rdm, wrm, wrpc, wrreg, ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Architectural RV32I decode: ALU numbering ADD..AND, immediates by arithmetic shifting.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] t;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          tbl [8];
        bit          alt;
        tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '{pc: pc, imm: 32'h0, alu: 0, sa: 0, sb: 0, rs1: ins[19:15], rs2: ins[24:20],
              rd: ins[11:7], f3: f3, shamt: {1'b0, ins[24:20]},
              br: 0, rdm: 0, wrm: 0, wrpc: 0, wrreg: 0, ill: 0};
        e.imm = $signed(ins) >>> 20;
        case (ins[6:0])
            7'h37: begin e.sa = 2; e.sb = 1; e.imm = {ins[31:12], 12'h0}; e.wrreg = 1; end
            7'h17: begin e.sa = 1; e.sb = 1; e.imm = {ins[31:12], 12'h0}; e.wrreg = 1; end
            7'h6F: begin
                e.sa = 1; e.sb = 2; e.wrpc = 1; e.wrreg = 1;
                t = {ins[31], ins[19:12], ins[20], ins[30:21], 12'h0};
                e.imm = $signed(t) >>> 11;
            end
            7'h67: begin e.sa = 1; e.sb = 2; e.wrpc = 1; e.wrreg = 1; end
            7'h63: begin
                e.alu = 1; e.br = 1;
                t = {ins[31], ins[7], ins[30:25], ins[11:8], 20'h0};
                e.imm = $signed(t) >>> 19;
            end
            7'h03: begin e.sb = 1; e.rdm = 1; e.wrreg = 1; end
            7'h23: begin
                e.sb = 1; e.wrm = 1;
                t = {ins[31:25], ins[11:7], 20'h0};
                e.imm = $signed(t) >>> 20;
            end
            7'h13: begin
                e.sb = 1; e.wrreg = 1;
                alt = (f3 == 3'd5) && f7[5];
                e.alu = tbl[f3] + int'(alt);
                if (f3 == 3'd1) e.ill = (f7 != 7'h00);
                if (f3 == 3'd5) e.ill = ((f7 & 7'b1011111) != 7'h00);
            end
            7'h33: begin
                e.wrreg = 1;
                alt = (f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5);
                e.alu = tbl[f3] + int'(alt);
                e.ill = !(f7 == 7'h00 || alt);
            end
            7'h0F: ;
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.br = 0; e.rdm = 0; e.wrm = 0; e.wrpc = 0; e.wrreg = 0; end
        if (e.rd == 5'd0) e.wrreg = 0;
        return e;
    endfunction

    task automatic compare_out(input exp_t e);
        check("pc",      out_pc_o,  e.pc);
        check("illegal", illegal_o, e.ill);
        check("branch",  Branch_o,  e.br);
        check("rdmem",   RdMem_o,   e.rdm);
        check("wrmem",   WrMem_o,   e.wrm);
        check("wrpc",    WrPc_o,    e.wrpc);
        check("wrreg",   WrReg_o,   e.wrreg);
        check("rs1",     rs1_o,     e.rs1);
        check("rs2",     rs2_o,     e.rs2);
        check("rd",      rd_o,      e.rd);
        check("funct3",  funct3_o,  e.f3);
        check("shamt",   shamt_o,   e.shamt);
        if (!e.ill) begin
            check("imm",  imm_o,        e.imm);
            check("alu",  ALUControl_o, 64'(e.alu));
            check("srcA", srcAE_o,      64'(e.sa));
            check("srcB", srcBE_o,      64'(e.sb));
        end
    endtask

    // One clock: drive at the negedge, check handshake/scoreboard, advance to next negedge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        bit in_x, out_x;
        in_valid_i  = v;
        inst_i      = ins;
        pc_i        = pc;
        out_ready_i = rdy & ~fl;
        flush_i     = fl;
        #1;
        check("in_ready",  in_ready_o,  64'(sb_q.size() < 2));
        check("out_valid", out_valid_o, 64'(sb_q.size() != 0));
        in_x  = v && in_ready_o;
        out_x = out_valid_o && out_ready_i;
        if (out_x && sb_q.size() != 0) compare_out(sb_q.pop_front());
        if (fl) sb_q.delete();
        else if (in_x) sb_q.push_back(model(ins, pc));
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 12);
        case (k)
            0: r[6:0] = 7'h37;   1: r[6:0] = 7'h17;   2: r[6:0] = 7'h6F;
            3: r[6:0] = 7'h67;   4: r[6:0] = 7'h63;   5: r[6:0] = 7'h03;
            6: r[6:0] = 7'h23;   7: r[6:0] = 7'h13;   8: r[6:0] = 7'h33;
            9: r[6:0] = 7'h0F;   10: r[6:0] = 7'h73;  default: ;
        endcase
        if (k == 7 || k == 8) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                default: ;
            endcase
        end
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        inst_i = 32'h0; pc_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_in_ready",  in_ready_o,  1);
        check("rst_pc",        out_pc_o,    0);
        check("rst_imm",       imm_o,       0);
        check("rst_alu",       ALUControl_o, 0);
        check("rst_fields",    {shamt_o, srcAE_o, srcBE_o, rs1_o, rs2_o, rd_o, funct3_o}, 0);
        check("rst_flags",     {Branch_o, RdMem_o, WrMem_o, WrPc_o, WrReg_o, illegal_o}, 0);
        rst_i = 1'b0;

        cycle(1, 32'h002081B3, 32'h100, 1, 0);
        check("add_valid", out_valid_o, 1);
        check("add_alu",   ALUControl_o, 0);
        check("add_src",   {srcAE_o, srcBE_o}, 0);
        check("add_regs",  {rs1_o, rs2_o, rd_o}, {5'd1, 5'd2, 5'd3});
        check("add_wrreg", WrReg_o, 1);
        check("add_ill",   illegal_o, 0);
        cycle(1, 32'h403100B3, 32'h104, 1, 0);
        check("sub_alu",   ALUControl_o, 1);
        cycle(1, 32'h26010193, 32'h108, 1, 0);
        check("addi_imm",  imm_o, 32'h260);
        check("addi_srcb", srcBE_o, 1);
        cycle(1, 32'hFFC1A103, 32'h10C, 1, 0);
        check("lw_imm",    imm_o, 32'hFFFFFFFC);
        check("lw_rdmem",  RdMem_o, 1);
        check("lw_f3",     funct3_o, 3'b010);
        check("lw_wrreg",  WrReg_o, 1);
        cycle(1, 32'h008000EF, 32'h110, 1, 0);
        check("jal_imm",   imm_o, 8);
        check("jal_wrpc",  WrPc_o, 1);
        check("jal_src",   {srcAE_o, srcBE_o}, {2'd1, 2'd2});
        cycle(1, 32'h00000073, 32'h114, 1, 0);
        check("ecall_ill", illegal_o, 1);
        check("ecall_en",  {Branch_o, RdMem_o, WrMem_o, WrPc_o, WrReg_o}, 0);
        cycle(1, 32'h0000007F, 32'h118, 1, 0);
        check("op7f_ill",  illegal_o, 1);
        check("op7f_en",   {Branch_o, RdMem_o, WrMem_o, WrPc_o, WrReg_o}, 0);
        cycle(1, 32'h26010013, 32'h11C, 1, 0);
        check("x0_ill",    illegal_o, 0);
        check("x0_wrreg",  WrReg_o, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Back-pressure: four instructions, output stalled for three cycles after the first.
        cycle(1, 32'h00100093, 32'h200, 1, 0);
        cycle(1, 32'h00200113, 32'h204, 0, 0);
        check("stream_ready_low", in_ready_o, 0);
        cycle(1, 32'h00300193, 32'h208, 0, 0);
        cycle(1, 32'h00300193, 32'h208, 0, 0);
        cycle(1, 32'h00300193, 32'h208, 1, 0);
        cycle(1, 32'h00300193, 32'h208, 1, 0);
        cycle(1, 32'h00400213, 32'h20C, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        check("stream_drained", 64'(sb_q.size()), 0);

        // Flush with output and skid full and a new instruction offered.
        cycle(1, 32'h00500293, 32'h300, 1, 0);
        cycle(1, 32'h00600313, 32'h304, 0, 0);
        cycle(1, 32'h00700393, 32'h308, 0, 1);
        check("flush_out_valid", out_valid_o, 0);
        check("flush_in_ready",  in_ready_o, 1);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);

        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, gen_inst(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
